vga_fb_scheduler: RTL and testbench

- Schedules a single-port, synchronous-read framebuffer RAM between three users:
  - VGA scan-out (read), driven by the VGA timing controller's `blank_n`, `nextX` and `nextY`;
  - two pixel-writer clients, each with a valid/ready handshake;
  - an internal clear engine.
- The framebuffer is stored at reduced resolution (each stored pixel covers a 2^SHIFT × 2^SHIFT screen block). Only one cycle in 2^SHIFT of active video needs a display read; every other cycle is a write slot.
- The block sits between the VGA timing controller, the framebuffer RAM and the drawing engines, and drives the pixel colour to the DAC.

---
 rtl/vga_fb_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/vga_fb_scheduler.sv | 159 +++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared types for the framebuffer scheduler: clear FSM states, RAM slot
// kinds and the framebuffer depth helper.
package vga_fb_pkg;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  typedef enum logic [2:0] {DISP, CLR, WR0, WR1, NONE} slot_t;

  function automatic int unsigned fb_depth(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a lone requester always wins, and on
// contention the client that was not granted last wins.
module rr_arbiter2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant = '0;
    if (enable) begin
      unique case (req)
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        default: grant = '0;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant[0])      last_d = 1'b0;
    else if (grant[1]) last_d = 1'b1;
  end

  // Starts at 1 so client 0 wins the first contention.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Shares a single-port framebuffer RAM between VGA scan-out, a clear engine
// and two pixel writers, and drives the upscaled pixel colour to the DAC.
module vga_fb_scheduler
  import vga_fb_pkg::*;
#(
  parameter int unsigned FB_W   = 200,
  parameter int unsigned FB_H   = 150,
  parameter int unsigned SHIFT  = 2,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              blank_n,
  input  logic [10:0]       nextX,
  input  logic [9:0]        nextY,
  output logic [PIX_W-1:0]  pixel,
  input  logic              wr0_valid,
  output logic              wr0_ready,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [PIX_W-1:0]  wr0_data,
  input  logic              wr1_valid,
  output logic              wr1_ready,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [PIX_W-1:0]  wr1_data,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_colour,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam int unsigned       FB_DEPTH  = fb_depth(FB_W, FB_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [10:0]       X_MASK    = 11'((1 << SHIFT) - 1);

  logic              disp_slot;
  logic [ADDR_W-1:0] disp_addr;
  logic [1:0]        grant;
  slot_t             slot;

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0]  colour_q, colour_d;

  logic              disp_d_q, blank_d_q;
  logic [PIX_W-1:0]  hold_q;

  assign disp_slot = blank_n && ((nextX & X_MASK) == '0);
  assign disp_addr = ADDR_W'(((32'(nextY) >> SHIFT) * FB_W) + (32'(nextX) >> SHIFT));

  // Writers only compete for slots not taken by scan-out or the clear engine.
  rr_arbiter2 u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .req    ({wr1_valid, wr0_valid}),
    .enable (!disp_slot && !clear_busy),
    .grant  (grant)
  );

  assign wr0_ready = grant[0];
  assign wr1_ready = grant[1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    colour_d = colour_q;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d  = CLEAR;
          cnt_d    = '0;
          colour_d = clear_colour;
        end
      end
      CLEAR: begin
        if (!disp_slot) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state_q == CLEAR);
  end

  always_comb begin
    slot = NONE;
    if (disp_slot)       slot = DISP;
    else if (clear_busy) slot = CLR;
    else if (grant[0])   slot = WR0;
    else if (grant[1])   slot = WR1;
  end

  // Out-of-range client writes still handshake but never reach the RAM.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (slot)
      DISP: mem_addr = disp_addr;
      CLR: begin
        mem_addr  = cnt_q;
        mem_we    = 1'b1;
        mem_wdata = colour_q;
      end
      WR0: begin
        mem_addr  = wr0_addr;
        mem_we    = (32'(wr0_addr) < FB_DEPTH);
        mem_wdata = wr0_data;
      end
      WR1: begin
        mem_addr  = wr1_addr;
        mem_we    = (32'(wr1_addr) < FB_DEPTH);
        mem_wdata = wr1_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      disp_d_q  <= 1'b0;
      blank_d_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      disp_d_q  <= disp_slot;
      blank_d_q <= blank_n;
      if (disp_d_q) hold_q <= mem_rdata;
    end
  end

  always_comb begin
    pixel = '0;
    if (blank_d_q) pixel = disp_d_q ? mem_rdata : hold_q;
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench: default-size instance for scan-out, arbitration and reset,
// plus a 4x2 instance for a complete clear sequence.
module tb_vga_fb_scheduler;

  logic        Clock = 1'b0;
  logic        Reset;
  always #5 Clock = ~Clock;

  logic        blank_n;
  logic [10:0] nextX;
  logic [9:0]  nextY;
  logic [7:0]  pixel;
  logic        wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [14:0] wr0_addr, wr1_addr;
  logic [7:0]  wr0_data, wr1_data;
  logic        clear_start, clear_busy;
  logic [7:0]  clear_colour;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        s_blank_n;
  logic [10:0] s_nextX;
  logic [9:0]  s_nextY;
  logic [7:0]  s_pixel;
  logic        s_wr0_valid, s_wr0_ready, s_wr1_valid, s_wr1_ready;
  logic [14:0] s_wr0_addr, s_wr1_addr;
  logic [7:0]  s_wr0_data, s_wr1_data;
  logic        s_clear_start, s_clear_busy;
  logic [7:0]  s_clear_colour;
  logic [14:0] s_mem_addr;
  logic        s_mem_we;
  logic [7:0]  s_mem_wdata, s_mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  vga_fb_scheduler u_dut (
    .Clock(Clock), .Reset(Reset), .blank_n(blank_n), .nextX(nextX), .nextY(nextY),
    .pixel(pixel), .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_valid(wr1_valid), .wr1_ready(wr1_ready),
    .wr1_addr(wr1_addr), .wr1_data(wr1_data), .clear_start(clear_start),
    .clear_colour(clear_colour), .clear_busy(clear_busy), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  vga_fb_scheduler #(.FB_W(4), .FB_H(2), .SHIFT(2), .PIX_W(8), .ADDR_W(15)) u_small (
    .Clock(Clock), .Reset(Reset), .blank_n(s_blank_n), .nextX(s_nextX), .nextY(s_nextY),
    .pixel(s_pixel), .wr0_valid(s_wr0_valid), .wr0_ready(s_wr0_ready),
    .wr0_addr(s_wr0_addr), .wr0_data(s_wr0_data), .wr1_valid(s_wr1_valid),
    .wr1_ready(s_wr1_ready), .wr1_addr(s_wr1_addr), .wr1_data(s_wr1_data),
    .clear_start(s_clear_start), .clear_colour(s_clear_colour),
    .clear_busy(s_clear_busy), .mem_addr(s_mem_addr), .mem_we(s_mem_we),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    blank_n = 1'b0; nextX = '0; nextY = '0; mem_rdata = '0;
    wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
    clear_start = 1'b0; clear_colour = '0;
    s_blank_n = 1'b0; s_nextX = '0; s_nextY = '0; s_mem_rdata = '0;
    s_wr0_valid = 1'b0; s_wr0_addr = 15'd5; s_wr0_data = 8'h01;
    s_wr1_valid = 1'b0; s_wr1_addr = '0; s_wr1_data = '0;
    s_clear_start = 1'b0; s_clear_colour = '0;

    #12;
    check("rst_pixel", pixel, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_ready0", wr0_ready, 0);
    check("rst_ready1", wr1_ready, 0);
    check("rst_we", mem_we, 0);
    tick();
    Reset = 1'b0;

    // Display read of block (1,2) and the pixel hold across the block.
    blank_n = 1'b1; nextX = 11'd4; nextY = 10'd8;
    #1;
    check("disp_addr", mem_addr, 401);
    check("disp_we", mem_we, 0);
    tick();
    mem_rdata = 8'hA5; nextX = 11'd5;
    #1 check("pix_x4", pixel, 8'hA5);
    tick();
    mem_rdata = 8'h00; nextX = 11'd6;
    #1 check("pix_x5", pixel, 8'hA5);
    tick();
    nextX = 11'd7;
    #1 check("pix_x6", pixel, 8'hA5);
    tick();
    nextX = 11'd8;
    #1 check("pix_x7", pixel, 8'hA5);
    tick();
    mem_rdata = 8'h5A; nextX = 11'd9;
    #1 check("pix_x8", pixel, 8'h5A);

    // Contention in blanking alternates starting with client 0.
    tick();
    blank_n = 1'b0; mem_rdata = '0;
    wr0_valid = 1'b1; wr0_addr = 15'd10; wr0_data = 8'h11;
    wr1_valid = 1'b1; wr1_addr = 15'd20; wr1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", wr0_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_ready1", wr1_ready, (i % 2 == 1) ? 1 : 0);
      check("rr_we", mem_we, 1);
      check("rr_addr", mem_addr, (i % 2 == 0) ? 10 : 20);
      check("rr_wdata", mem_wdata, (i % 2 == 0) ? 8'h11 : 8'h22);
      tick();
    end
    blank_n = 1'b1; nextX = 11'd8; nextY = 10'd0;
    #1;
    check("act_disp_r0", wr0_ready, 0);
    check("act_disp_r1", wr1_ready, 0);
    check("act_disp_we", mem_we, 0);
    check("act_disp_addr", mem_addr, 2);
    tick();
    nextX = 11'd9;
    #1;
    check("act_w_r0", wr0_ready, 1);
    check("act_w_addr", mem_addr, 10);
    tick();
    nextX = 11'd10;
    #1 check("act_w_r1", wr1_ready, 1);
    tick();
    wr0_valid = 1'b0; wr1_valid = 1'b0;

    // Out-of-range write handshakes without writing.
    blank_n = 1'b0; wr0_valid = 1'b1; wr0_addr = 15'd30000; wr0_data = 8'h09;
    #1;
    check("oor_ready", wr0_ready, 1);
    check("oor_we", mem_we, 0);
    tick();
    wr0_valid = 1'b0;

    // Load hold with FF, then blank it.
    blank_n = 1'b1; nextX = 11'd0; nextY = 10'd0;
    tick();
    mem_rdata = 8'hFF; blank_n = 1'b0;
    #1 check("blank_pre", pixel, 8'hFF);
    tick();
    mem_rdata = 8'h00;
    #1 check("blank_mask", pixel, 0);

    // Clear during active non-display cycles, aborted by reset at address 3.
    blank_n = 1'b1; nextX = 11'd1; nextY = 10'd0;
    clear_start = 1'b1; clear_colour = 8'hC3;
    tick();
    clear_start = 1'b0;
    #1;
    check("clr_busy", clear_busy, 1);
    check("clr_addr0", mem_addr, 0);
    check("clr_hold_pix", pixel, 8'hFF);
    tick(); tick(); tick();
    check("clr_addr3", mem_addr, 3);
    check("clr_wdata", mem_wdata, 8'hC3);
    check("clr_we", mem_we, 1);
    Reset = 1'b1;
    #1;
    check("arst_busy", clear_busy, 0);
    check("arst_pixel", pixel, 0);
    tick();
    Reset = 1'b0; blank_n = 1'b0;
    wr1_valid = 1'b1; wr1_addr = 15'd100; wr1_data = 8'h77;
    #1;
    check("post_rst_ready1", wr1_ready, 1);
    check("post_rst_we", mem_we, 1);
    check("post_rst_addr", mem_addr, 100);
    tick();
    wr1_valid = 1'b0;

    // Full clear of the 4x2 framebuffer while client 0 keeps requesting.
    s_wr0_valid = 1'b1; s_clear_start = 1'b1; s_clear_colour = 8'h3C;
    #1;
    check("s_start_grant", s_wr0_ready, 1);
    check("s_start_busy", s_clear_busy, 0);
    tick();
    s_clear_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("s_busy", s_clear_busy, 1);
      check("s_addr", s_mem_addr, i);
      check("s_we", s_mem_we, 1);
      check("s_wdata", s_mem_wdata, 8'h3C);
      check("s_ready0", s_wr0_ready, 0);
      tick();
    end
    #1;
    check("s_done_busy", s_clear_busy, 0);
    check("s_done_ready0", s_wr0_ready, 1);
    check("s_done_addr", s_mem_addr, 5);
    s_wr0_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
